ram_port_arbiter: RTL and testbench

- Shares the single read/write port of the 512x64-bit unified RAM between two requesters: master 0 (core load/store unit) and master 1 (debug/DMA loader).
- Requests use a valid/ready handshake. Grants are round-robin, with one transaction outstanding at a time.
- Captures read data into a register and returns it as a one-cycle response pulse.
- Filters out-of-range addresses before they reach the RAM. The read-only (instruction) port is not touched by this block.

---
 rtl/ram_port_arbiter.sv | 250 +++++++++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares the single read/write port of the 512x64 unified RAM between the
// core load/store unit (master 0) and the debug/DMA loader (master 1).
// One transaction is in flight at a time: IDLE -> ACCESS -> RESP -> IDLE.
// Ties are broken round-robin, and out-of-range addresses never write the RAM.
module ram_port_arbiter #(
    parameter int ADDR_W    = 33,
    parameter int MEM_BYTES = 4096
) (
    input  logic              clk,
    input  logic              rst,

    // master 0 (core load/store unit)
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic              m0_req_wen,
    input  logic [ADDR_W-1:0] m0_req_addr,
    input  logic [63:0]       m0_req_wdata,
    input  logic [7:0]        m0_req_wmask,
    output logic              m0_resp_valid,
    output logic [63:0]       m0_resp_rdata,
    output logic              m0_resp_err,

    // master 1 (debug/DMA loader)
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic              m1_req_wen,
    input  logic [ADDR_W-1:0] m1_req_addr,
    input  logic [63:0]       m1_req_wdata,
    input  logic [7:0]        m1_req_wmask,
    output logic              m1_resp_valid,
    output logic [63:0]       m1_resp_rdata,
    output logic              m1_resp_err,

    // RAM read/write port
    output logic              rw_wmode,
    output logic [ADDR_W-1:0] rw_addr,
    output logic [63:0]       rw_wdata,
    output logic [7:0]        rw_wmask,
    input  logic [63:0]       rw_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // First byte address that lies outside the RAM.
    localparam logic [ADDR_W-1:0] LP_MEM_LIMIT = ADDR_W'(MEM_BYTES);

    state_t              r_state;
    state_t              w_state_nxt;

    // Request captured at the handshake edge.
    logic                r_wen;
    logic [ADDR_W-1:0]   r_addr;
    logic [63:0]         r_wdata;
    logic [7:0]          r_wmask;
    logic                r_owner;
    logic                r_err;

    // 1 = master 1 was granted last; reset value lets master 0 win the first tie.
    logic                r_last_grant;

    // Registered response outputs, one set per master.
    logic                r_m0_resp_valid;
    logic [63:0]         r_m0_resp_rdata;
    logic                r_m0_resp_err;
    logic                r_m1_resp_valid;
    logic [63:0]         r_m1_resp_rdata;
    logic                r_m1_resp_err;

    // Arbitration and handshake.
    logic                w_grant0;
    logic                w_grant1;
    logic                w_handshake;
    logic                w_m0_ready;
    logic                w_m1_ready;
    logic                w_wmode;

    // Winning request fields.
    logic                w_sel_wen;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [63:0]         w_sel_wdata;
    logic [7:0]          w_sel_wmask;
    logic                w_sel_err;

    // Data captured into the response at the end of ACCESS.
    logic [63:0]         w_rdata_cap;

    // Round-robin winner among valid requesters; the master not granted last wins a tie.
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (m0_req_valid && m1_req_valid) begin
            w_grant0 = r_last_grant;
            w_grant1 = !r_last_grant;
        end else begin
            w_grant0 = m0_req_valid;
            w_grant1 = m1_req_valid;
        end
    end

    // Steer the winning master's request fields toward the capture registers.
    always_comb begin
        w_sel_wen   = 1'b0;
        w_sel_addr  = {ADDR_W{1'b0}};
        w_sel_wdata = 64'd0;
        w_sel_wmask = 8'd0;
        if (w_grant1) begin
            w_sel_wen   = m1_req_wen;
            w_sel_addr  = m1_req_addr;
            w_sel_wdata = m1_req_wdata;
            w_sel_wmask = m1_req_wmask;
        end else begin
            w_sel_wen   = m0_req_wen;
            w_sel_addr  = m0_req_addr;
            w_sel_wdata = m0_req_wdata;
            w_sel_wmask = m0_req_wmask;
        end
        w_sel_err = (w_sel_addr >= LP_MEM_LIMIT);
    end

    // State register; reset aborts any in-flight transaction immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the combinational ready and RAM write-enable outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_m0_ready  = 1'b0;
        w_m1_ready  = 1'b0;
        w_handshake = 1'b0;
        w_wmode     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_m0_ready = w_grant0;
                w_m1_ready = w_grant1;
                if (w_grant0 || w_grant1) begin
                    w_handshake = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                w_wmode     = r_wen && !r_err;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Capture the accepted request and remember who was granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wen        <= 1'b0;
            r_addr       <= {ADDR_W{1'b0}};
            r_wdata      <= 64'd0;
            r_wmask      <= 8'd0;
            r_owner      <= 1'b0;
            r_err        <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (w_handshake) begin
            r_wen        <= w_sel_wen;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_wmask      <= w_sel_wmask;
            r_owner      <= w_grant1;
            r_err        <= w_sel_err;
            r_last_grant <= w_grant1;
        end else begin
            r_wen        <= r_wen;
            r_addr       <= r_addr;
            r_wdata      <= r_wdata;
            r_wmask      <= r_wmask;
            r_owner      <= r_owner;
            r_err        <= r_err;
            r_last_grant <= r_last_grant;
        end
    end

    // Only an error-free read returns RAM data; writes and errors return zero.
    always_comb begin
        w_rdata_cap = 64'd0;
        if (!r_wen && !r_err) begin
            w_rdata_cap = rw_rdata;
        end else begin
            w_rdata_cap = 64'd0;
        end
    end

    // Load the owner's response at the end of ACCESS so it is visible for exactly the RESP cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m0_resp_valid <= 1'b0;
            r_m0_resp_rdata <= 64'd0;
            r_m0_resp_err   <= 1'b0;
            r_m1_resp_valid <= 1'b0;
            r_m1_resp_rdata <= 64'd0;
            r_m1_resp_err   <= 1'b0;
        end else if (r_state == ST_ACCESS) begin
            r_m0_resp_valid <= !r_owner;
            r_m0_resp_rdata <= r_owner ? 64'd0 : w_rdata_cap;
            r_m0_resp_err   <= !r_owner && r_err;
            r_m1_resp_valid <= r_owner;
            r_m1_resp_rdata <= r_owner ? w_rdata_cap : 64'd0;
            r_m1_resp_err   <= r_owner && r_err;
        end else begin
            r_m0_resp_valid <= 1'b0;
            r_m0_resp_rdata <= 64'd0;
            r_m0_resp_err   <= 1'b0;
            r_m1_resp_valid <= 1'b0;
            r_m1_resp_rdata <= 64'd0;
            r_m1_resp_err   <= 1'b0;
        end
    end

    assign m0_req_ready  = w_m0_ready;
    assign m1_req_ready  = w_m1_ready;

    assign m0_resp_valid = r_m0_resp_valid;
    assign m0_resp_rdata = r_m0_resp_rdata;
    assign m0_resp_err   = r_m0_resp_err;
    assign m1_resp_valid = r_m1_resp_valid;
    assign m1_resp_rdata = r_m1_resp_rdata;
    assign m1_resp_err   = r_m1_resp_err;

    // The RAM always sees the latched request; only the write enable is state-gated.
    assign rw_wmode = w_wmode;
    assign rw_addr  = r_addr;
    assign rw_wdata = r_wdata;
    assign rw_wmask = r_wmask;

    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed, table-driven bench for ram_port_arbiter with a behavioural 512x64 RAM.
module tb_ram_port_arbiter;

    localparam int ADDR_W = 33;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req_valid, m0_req_ready, m0_req_wen;
    logic [ADDR_W-1:0] m0_req_addr;
    logic [63:0]       m0_req_wdata;
    logic [7:0]        m0_req_wmask;
    logic              m0_resp_valid, m0_resp_err;
    logic [63:0]       m0_resp_rdata;
    logic              m1_req_valid, m1_req_ready, m1_req_wen;
    logic [ADDR_W-1:0] m1_req_addr;
    logic [63:0]       m1_req_wdata;
    logic [7:0]        m1_req_wmask;
    logic              m1_resp_valid, m1_resp_err;
    logic [63:0]       m1_resp_rdata;
    logic              rw_wmode;
    logic [ADDR_W-1:0] rw_addr;
    logic [63:0]       rw_wdata;
    logic [7:0]        rw_wmask;
    logic [63:0]       rw_rdata;
    logic              busy;

    logic              preset_en;
    logic [63:0]       mem [0:511];

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int              m;
        logic            wen;
        logic [ADDR_W-1:0] addr;
        logic [63:0]     wdata;
        logic [7:0]      wmask;
        logic [63:0]     exp_rdata;
        logic            exp_err;
    } vec_t;

    vec_t vecs [11];

    ram_port_arbiter #(.ADDR_W(ADDR_W), .MEM_BYTES(4096)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_wen(m0_req_wen),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_wmask(m0_req_wmask),
        .m0_resp_valid(m0_resp_valid), .m0_resp_rdata(m0_resp_rdata), .m0_resp_err(m0_resp_err),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_wen(m1_req_wen),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_wmask(m1_req_wmask),
        .m1_resp_valid(m1_resp_valid), .m1_resp_rdata(m1_resp_rdata), .m1_resp_err(m1_resp_err),
        .rw_wmode(rw_wmode), .rw_addr(rw_addr), .rw_wdata(rw_wdata), .rw_wmask(rw_wmask),
        .rw_rdata(rw_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, byte-masked write on the rising edge.
    assign rw_rdata = mem[rw_addr[11:3]];

    always @(posedge clk) begin
        if (preset_en) begin
            for (int i = 0; i < 512; i++) begin
                mem[i] <= (i == 4) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'hA5A5_0000_0000_0000 | 64'(i));
            end
        end else if (rw_wmode) begin
            for (int b = 0; b < 8; b++) begin
                if (rw_wmask[b]) mem[rw_addr[11:3]][8*b +: 8] <= rw_wdata[8*b +: 8];
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input int m, input logic v, input logic wen, input logic [ADDR_W-1:0] a,
                         input logic [63:0] d, input logic [7:0] k);
        if (m == 0) begin
            m0_req_valid = v; m0_req_wen = wen; m0_req_addr = a; m0_req_wdata = d; m0_req_wmask = k;
        end else begin
            m1_req_valid = v; m1_req_wen = wen; m1_req_addr = a; m1_req_wdata = d; m1_req_wmask = k;
        end
    endtask

    function automatic logic rdy(input int m);
        return (m == 0) ? m0_req_ready : m1_req_ready;
    endfunction

    // One full transaction: handshake, ACCESS, RESP, back to IDLE.
    task automatic txn(input vec_t v, input string nm);
        int n;
        @(negedge clk);
        drive(v.m, 1'b1, v.wen, v.addr, v.wdata, v.wmask);
        #1;
        n = 0;
        while (!rdy(v.m) && n < 8) begin
            @(negedge clk); #1; n++;
        end
        chk({nm, "_ready"}, 64'(rdy(v.m)), 64'd1);
        chk({nm, "_wait"}, 64'(n), 64'd0);
        @(negedge clk);
        drive(v.m, 1'b0, 1'b0, '0, 64'd0, 8'd0);
        #1;
        chk({nm, "_acc_busy"}, 64'(busy), 64'd1);
        chk({nm, "_acc_ready"}, 64'(m0_req_ready | m1_req_ready), 64'd0);
        chk({nm, "_acc_wmode"}, 64'(rw_wmode), 64'(v.wen && !v.exp_err));
        chk({nm, "_acc_addr"}, 64'(rw_addr), 64'(v.addr));
        @(negedge clk); #1;
        chk({nm, "_resp_valid"}, 64'(v.m == 0 ? m0_resp_valid : m1_resp_valid), 64'd1);
        chk({nm, "_other_valid"}, 64'(v.m == 0 ? m1_resp_valid : m0_resp_valid), 64'd0);
        chk({nm, "_rdata"}, v.m == 0 ? m0_resp_rdata : m1_resp_rdata, v.exp_rdata);
        chk({nm, "_err"}, 64'(v.m == 0 ? m0_resp_err : m1_resp_err), 64'(v.exp_err));
        chk({nm, "_resp_wmode"}, 64'(rw_wmode), 64'd0);
        @(negedge clk); #1;
        chk({nm, "_pulse_end"}, 64'(m0_resp_valid | m1_resp_valid), 64'd0);
        chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int g_m [4];
        int g_c [4];
        int ng, both, r0, r1, idx, nr;
        logic upd;
        logic [ADDR_W-1:0] b2b_addr [3];
        logic [63:0]       b2b_exp  [3];
        vec_t rv;

        //        m  wen   addr                  wdata                     mask   exp_rdata                  err
        vecs[0]  = '{0, 1'b1, 33'h0_0000_0010, 64'h1122_3344_5566_7788, 8'hFF, 64'h0,                     1'b0};
        vecs[1]  = '{0, 1'b0, 33'h0_0000_0010, 64'h0,                   8'h00, 64'h1122_3344_5566_7788, 1'b0};
        vecs[2]  = '{1, 1'b1, 33'h0_0000_0020, 64'h0,                   8'h0F, 64'h0,                     1'b0};
        vecs[3]  = '{1, 1'b0, 33'h0_0000_0020, 64'h0,                   8'h00, 64'hFFFF_FFFF_0000_0000, 1'b0};
        vecs[4]  = '{0, 1'b1, 33'h0_0000_1000, 64'hDEAD,                8'hFF, 64'h0,                     1'b1};
        vecs[5]  = '{0, 1'b0, 33'h0_0000_0000, 64'h0,                   8'h00, 64'hA5A5_0000_0000_0000, 1'b0};
        vecs[6]  = '{1, 1'b1, 33'h0_0000_0028, 64'h1234,                8'h00, 64'h0,                     1'b0};
        vecs[7]  = '{1, 1'b0, 33'h0_0000_0028, 64'h0,                   8'h00, 64'hA5A5_0000_0000_0005, 1'b0};
        vecs[8]  = '{0, 1'b0, 33'h0_0000_0013, 64'h0,                   8'h00, 64'h1122_3344_5566_7788, 1'b0};
        vecs[9]  = '{1, 1'b0, 33'h0_0000_2000, 64'h0,                   8'h00, 64'h0,                     1'b1};
        vecs[10] = '{0, 1'b0, 33'h1_0000_0000, 64'h0,                   8'h00, 64'h0,                     1'b1};

        // Reset and RAM preset.
        rst = 1'b1;
        preset_en = 1'b1;
        drive(0, 1'b0, 1'b0, '0, 64'd0, 8'd0);
        drive(1, 1'b0, 1'b0, '0, 64'd0, 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        preset_en = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_wmode", 64'(rw_wmode), 64'd0);
        chk("rst_rw_bus", {31'd0, rw_addr} | rw_wdata | 64'(rw_wmask), 64'd0);
        chk("rst_resp_valid", 64'(m0_resp_valid | m1_resp_valid), 64'd0);
        chk("rst_resp_err", 64'(m0_resp_err | m1_resp_err), 64'd0);
        chk("rst_resp_rdata", m0_resp_rdata | m1_resp_rdata, 64'd0);
        chk("rst_ready", 64'(m0_req_ready | m1_req_ready), 64'd0);

        // Both masters valid out of reset: m0, m1, m0, m1 every 3 cycles.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 33'h0, 64'd0, 8'd0);
        drive(1, 1'b1, 1'b0, 33'h8, 64'd0, 8'd0);
        rst = 1'b0;
        ng = 0; both = 0; r0 = 0; r1 = 0;
        for (int c = 0; c < 12; c++) begin
            #1;
            if (m0_req_ready && m1_req_ready) both++;
            if ((m0_req_ready || m1_req_ready) && ng < 4) begin
                g_m[ng] = m1_req_ready ? 1 : 0;
                g_c[ng] = c;
                ng++;
            end
            if (m0_resp_valid) r0++;
            if (m1_resp_valid) r1++;
            if (c == 11) begin
                drive(0, 1'b0, 1'b0, '0, 64'd0, 8'd0);
                drive(1, 1'b0, 1'b0, '0, 64'd0, 8'd0);
            end
            @(negedge clk);
        end
        chk("arb_grants", 64'(ng), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ng) begin
                chk($sformatf("arb_owner%0d", i), 64'(g_m[i]), 64'(i % 2));
                chk($sformatf("arb_cycle%0d", i), 64'(g_c[i]), 64'(3 * i));
            end
        end
        chk("arb_both_ready", 64'(both), 64'd0);
        chk("arb_m0_resps", 64'(r0), 64'd2);
        chk("arb_m1_resps", 64'(r1), 64'd2);

        // Table-driven single transactions.
        for (int i = 0; i < 11; i++) txn(vecs[i], $sformatf("v%0d", i));

        // m1 back-to-back reads with valid held: accepted at cycles 0, 3, 6.
        b2b_addr[0] = 33'h0;  b2b_exp[0] = 64'hA5A5_0000_0000_0000;
        b2b_addr[1] = 33'h8;  b2b_exp[1] = 64'hA5A5_0000_0000_0001;
        b2b_addr[2] = 33'h10; b2b_exp[2] = 64'h1122_3344_5566_7788;
        @(negedge clk);
        drive(1, 1'b1, 1'b0, b2b_addr[0], 64'd0, 8'd0);
        idx = 0; nr = 0; upd = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (upd) begin
                if (idx < 3) drive(1, 1'b1, 1'b0, b2b_addr[idx], 64'd0, 8'd0);
                else drive(1, 1'b0, 1'b0, '0, 64'd0, 8'd0);
                upd = 1'b0;
            end
            #1;
            if (m1_req_ready) begin
                if (idx < 3) g_c[idx] = c;
                idx++;
                upd = 1'b1;
            end
            if (m1_resp_valid) begin
                if (nr < 3) chk($sformatf("b2b_rdata%0d", nr), m1_resp_rdata, b2b_exp[nr]);
                nr++;
            end
            if (m0_resp_valid) chk("b2b_m0_valid", 64'(m0_resp_valid), 64'd0);
            @(negedge clk);
        end
        drive(1, 1'b0, 1'b0, '0, 64'd0, 8'd0);
        chk("b2b_handshakes", 64'(idx), 64'd3);
        chk("b2b_responses", 64'(nr), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < idx) chk($sformatf("b2b_cycle%0d", i), 64'(g_c[i]), 64'(3 * i));
        end

        // Reset in the middle of the ACCESS cycle of a write to 0x18.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 33'h18, 64'h0BAD_0BAD_0BAD_0BAD, 8'hFF);
        #1;
        ng = 0;
        while (!m0_req_ready && ng < 8) begin
            @(negedge clk); #1; ng++;
        end
        chk("mid_ready", 64'(m0_req_ready), 64'd1);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, '0, 64'd0, 8'd0);
        #1;
        chk("mid_wmode_before", 64'(rw_wmode), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_wmode_drop", 64'(rw_wmode), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        r0 = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (m0_resp_valid || m1_resp_valid) r0++;
            @(negedge clk);
        end
        chk("mid_no_resp", 64'(r0), 64'd0);
        chk("mid_mem_0x18", mem[3], 64'hA5A5_0000_0000_0003);
        rv = '{0, 1'b0, 33'h18, 64'h0, 8'h00, 64'hA5A5_0000_0000_0003, 1'b0};
        txn(rv, "mid_readback");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
